// File: rtl/column_prefetch_buffer.sv
// Column prefetch double buffer between texture ROM and strip controller.
// Optional macro COLUMN_PREFETCH_DROP_CNT_EN enables the drop counter.
module column_prefetch_buffer #(
  parameter int LED_COUNT   = 52,
  parameter int TEX_WIDTH   = 64,
  parameter int COL_BITS    = 6,
  parameter int PX_IDX_BITS = 6,
  parameter int DATA_WIDTH  = 24,
  parameter int ADDR_WIDTH  = 17,
  parameter int ROM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COL_BITS-1:0]    col,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_data,
  input  logic                   sof,
  input  logic [PX_IDX_BITS-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0]  rd_pixel,
  output logic [COL_BITS-1:0]    front_col,
  output logic                   busy,
  output logic [15:0]            drop_cnt
);

  localparam int FILL_LEN = LED_COUNT + ROM_LATENCY;
  localparam int CW = $clog2(FILL_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    READY
  } state_t;

  state_t                 state;
  logic [COL_BITS-1:0]    lat_col;
  logic [ADDR_WIDTH-1:0]  lat_base;
  logic                   first;
  logic                   sel;
  logic                   front_valid;
  logic [CW-1:0]          cnt;
  logic                   chg;
  logic                   start;
  logic                   we;
  logic [CW-1:0]          wr_idx;

  logic [DATA_WIDTH-1:0] buf0 [LED_COUNT];
  logic [DATA_WIDTH-1:0] buf1 [LED_COUNT];

  function automatic logic [ADDR_WIDTH-1:0] addr_of(
    input logic [CW-1:0]         idx,
    input logic [ADDR_WIDTH-1:0] b,
    input logic [COL_BITS-1:0]   c
  );
    logic [ADDR_WIDTH-1:0] row;
    row = ADDR_WIDTH'(idx) * ADDR_WIDTH'(TEX_WIDTH);
    return b + row + ADDR_WIDTH'(c);
  endfunction

  assign chg = (col != lat_col) || (base_addr != lat_base);

  // Decide when a new fill (re)starts and when a ROM word lands in back.
  always_comb begin
    start  = 1'b0;
    we     = 1'b0;
    wr_idx = cnt - CW'(ROM_LATENCY);
    unique case (state)
      IDLE:    start = chg || first;
      FILL:    start = chg;
      READY:   start = chg && !sof;
      default: start = 1'b0;
    endcase
    if (state == FILL && !chg && cnt >= CW'(ROM_LATENCY))
      we = 1'b1;
  end

  // Control FSM: latch request, walk fill addresses, swap on sof.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rom_addr    <= '0;
      front_col   <= '0;
      busy        <= 1'b0;
      front_valid <= 1'b0;
      lat_col     <= '0;
      lat_base    <= '0;
      first       <= 1'b1;
      sel         <= 1'b0;
      cnt         <= '0;
    end else if (start) begin
      lat_col  <= col;
      lat_base <= base_addr;
      cnt      <= '0;
      rom_addr <= addr_of('0, base_addr, col);
      first    <= 1'b0;
      busy     <= 1'b1;
      state    <= FILL;
    end else begin
      unique case (state)
        FILL: begin
          if (cnt == CW'(FILL_LEN - 1)) begin
            busy  <= 1'b0;
            state <= READY;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt < CW'(LED_COUNT - 1))
              rom_addr <= addr_of(cnt + CW'(1),
                                  lat_base, lat_col);
          end
        end
        READY: begin
          if (sof) begin
            sel         <= ~sel;
            front_col   <= lat_col;
            front_valid <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= state;
      endcase
    end
  end

  // Back-buffer write; sel picks the front, the other array is back.
  always_ff @(posedge clk) begin
    if (we) begin
      if (sel)
        buf0[wr_idx] <= rom_data;
      else
        buf1[wr_idx] <= rom_data;
    end
  end

  // Registered front-buffer read, zero when out of range or empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rd_pixel <= '0;
    else if (front_valid &&
             {1'b0, rd_idx} < (PX_IDX_BITS + 1)'(LED_COUNT))
      rd_pixel <= sel ? buf1[rd_idx] : buf0[rd_idx];
    else
      rd_pixel <= '0;
  end

`ifdef COLUMN_PREFETCH_DROP_CNT_EN
  logic drop;
  assign drop = (state == READY) && chg && !sof;

  // Saturating count of ready columns replaced before a swap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_column_prefetch_buffer.sv
// Directed bench for column_prefetch_buffer.
// ROM model returns its address as data, one cycle late.
module tb_column_prefetch_buffer;

  logic        clk;
  logic        reset;
  logic [5:0]  col;
  logic [16:0] base_addr;
  logic [16:0] rom_addr;
  logic [23:0] rom_data;
  logic        sof;
  logic [5:0]  rd_idx;
  logic [23:0] rd_pixel;
  logic [5:0]  front_col;
  logic        busy;
  logic [15:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef COLUMN_PREFETCH_DROP_CNT_EN
  localparam int EXP_DROP = 1;
`else
  localparam int EXP_DROP = 0;
`endif

  column_prefetch_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .col       (col),
    .base_addr (base_addr),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .sof       (sof),
    .rd_idx    (rd_idx),
    .rd_pixel  (rd_pixel),
    .front_col (front_col),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= 24'(rom_addr);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_run(input int c, input int b,
                          input bit ca, input int len);
    int n;
    int g;
    n = 0;
    g = 0;
    while (!busy && g < 10) begin
      tick();
      g++;
    end
    while (busy && n < 200) begin
      if (ca && n < 52)
        chk("fill_addr", 32'(rom_addr), 32'(b + n * 64 + c));
      tick();
      n++;
    end
    chk("busy_len", 32'(n), 32'(len));
  endtask

  task automatic pulse_sof();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  initial begin
    int g;
    reset = 1'b1;
    col = 6'd5;
    base_addr = '0;
    sof = 1'b0;
    rd_idx = '0;
    repeat (3) tick();
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_pix", 32'(rd_pixel), 0);
    chk("rst_fcol", 32'(front_col), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop", 32'(drop_cnt), 0);

    reset = 1'b0;
    fill_run(5, 0, 1'b1, 53);
    rd_idx = 6'd2;
    tick();
    chk("pix_nosof", 32'(rd_pixel), 0);
    pulse_sof();
    chk("fcol5", 32'(front_col), 5);
    tick();
    chk("pix5_2", 32'(rd_pixel), 133);

    col = 6'd4;
    fill_run(4, 0, 1'b0, 53);
    chk("fcol_hold", 32'(front_col), 5);
    col = 6'd6;
    tick();
    fill_run(6, 0, 1'b1, 53);
    chk("drop1", 32'(drop_cnt), 32'(EXP_DROP));
    chk("fcol_pre6", 32'(front_col), 5);
    rd_idx = 6'd0;
    pulse_sof();
    chk("fcol6", 32'(front_col), 6);
    tick();
    chk("pix6_0", 32'(rd_pixel), 6);

    col = 6'd7;
    g = 0;
    while (!busy && g < 10) begin
      tick();
      g++;
    end
    chk("ab_addr0", 32'(rom_addr), 7);
    repeat (20) tick();
    chk("ab_addr20", 32'(rom_addr), 1287);
    col = 6'd8;
    tick();
    chk("ab_busy", 32'(busy), 1);
    fill_run(8, 0, 1'b1, 53);
    pulse_sof();
    chk("fcol8", 32'(front_col), 8);
    for (int i = 0; i < 52; i++) begin
      rd_idx = 6'(i);
      tick();
      chk("pix8", 32'(rd_pixel), 32'(8 + i * 64));
    end
    chk("drop_ab", 32'(drop_cnt), 32'(EXP_DROP));

    col = 6'd9;
    fill_run(9, 0, 1'b0, 53);
    col = 6'd10;
    pulse_sof();
    chk("both_fcol", 32'(front_col), 9);
    chk("both_busy0", 32'(busy), 0);
    tick();
    chk("both_busy1", 32'(busy), 1);
    chk("both_addr", 32'(rom_addr), 10);
    chk("both_drop", 32'(drop_cnt), 32'(EXP_DROP));
    fill_run(10, 0, 1'b1, 53);
    rd_idx = 6'd1;
    tick();
    chk("pix9_1", 32'(rd_pixel), 73);
    pulse_sof();
    chk("fcol10", 32'(front_col), 10);

    rd_idx = 6'd52;
    tick();
    chk("pix_idx52", 32'(rd_pixel), 0);
    rd_idx = 6'd63;
    tick();
    chk("pix_idx63", 32'(rd_pixel), 0);
    rd_idx = 6'd51;
    tick();
    chk("pix_idx51", 32'(rd_pixel), 3274);

    col = 6'd11;
    base_addr = 17'd1000;
    tick();
    chk("b_addr0", 32'(rom_addr), 1011);
    pulse_sof();
    chk("sof_fill_fcol", 32'(front_col), 10);
    chk("sof_fill_busy", 32'(busy), 1);
    fill_run(11, 1000, 1'b0, 52);
    rd_idx = 6'd5;
    pulse_sof();
    chk("fcol11", 32'(front_col), 11);
    tick();
    chk("pix11_5", 32'(rd_pixel), 1331);

    col = 6'd12;
    base_addr = '0;
    tick();
    repeat (30) tick();
    chk("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    col = 6'd0;
    #1;
    chk("mr_addr", 32'(rom_addr), 0);
    chk("mr_pix", 32'(rd_pixel), 0);
    chk("mr_fcol", 32'(front_col), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_drop", 32'(drop_cnt), 0);
    repeat (2) tick();
    reset = 1'b0;
    fill_run(0, 0, 1'b1, 53);
    rd_idx = 6'd1;
    tick();
    chk("mr_pix_nv", 32'(rd_pixel), 0);
    pulse_sof();
    tick();
    chk("mr_pix0_1", 32'(rd_pixel), 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
